dmx_rx: RTL
===========

DMX_RX -- requirements
Module: dmx_rx

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 48, giving clk_In cycles per DMX bit (12.09 MHz / 250 kbaud, rounded).
REQ-002 The module SHALL have parameter BREAK_MIN, default 1064, giving the minimum low cycles accepted as a break (88 us).
REQ-003 The module SHALL have parameter MAB_MIN, default 97, giving the minimum high cycles accepted as mark-after-break (8 us).
REQ-004 clk_In  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 RX  input  1  asynchronous DMX512 line, idle high.
REQ-007 slot_data  output  8  last received slot byte.
REQ-008 slot_addr  output  10  index of slot_data; 0 is the start code, 1..512 are channels.
REQ-009 slot_valid  output  1  one-cycle strobe; slot_data and slot_addr are valid.
REQ-010 frame_start  output  1  one-cycle strobe when a valid break+MAB is completed.
REQ-011 frame_end  output  1  one-cycle strobe when a frame with at least one slot closes.
REQ-012 frame_err  output  1  one-cycle strobe on a framing, MAB or false-start error.

Function
REQ-013 RX SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (2-cycle input latency).
REQ-014 The FSM states SHALL be IDLE, BREAK, MAB, START, DATA, STOP1, STOP2.
REQ-015 A low-run counter SHALL run in every state, saturate at BREAK_MIN and clear on synchronized high.
REQ-016 When the low-run reaches BREAK_MIN in any state, the FSM SHALL enter BREAK, abandon any byte in progress, and pulse frame_end if at least one slot of the current frame was delivered.
REQ-017 In BREAK, RX high SHALL move the FSM to MAB with a high-counter cleared.
REQ-018 In MAB, RX low with high-counter >= MAB_MIN SHALL pulse frame_start, set the next slot index to 0 and enter START. RX low earlier SHALL pulse frame_err and return to IDLE.
REQ-019 START SHALL wait CLK_DIV/2 cycles and resample. Low enters DATA. High is a false start: pulse frame_err and return to IDLE.
REQ-020 DATA SHALL sample 8 bits LSB-first at CLK_DIV-cycle intervals from the mid-start point.
REQ-021 STOP1 and STOP2 SHALL each sample at the next CLK_DIV interval.
REQ-022 A low sample in STOP1 or STOP2 SHALL pulse frame_err, discard the byte and enter IDLE; the frame then closes only at the next break.
REQ-023 After a high STOP2 sample, the module SHALL pulse slot_valid and update slot_data and slot_addr in the same cycle.
REQ-024 After the slot_valid of REQ-023, a falling edge SHALL go to START for the next slot; if slot_addr was 512, the module SHALL pulse frame_end and go to IDLE.
REQ-025 The mark-between-slots length SHALL be unbounded; the FSM waits for the falling edge.
REQ-026 IDLE SHALL ignore all activity except break detection.
REQ-027 If break detection and a stop-bit sample occur in the same cycle, break SHALL take precedence.
REQ-028 slot_data and slot_addr SHALL hold their value between strobes.

Reset
REQ-029 While rst_n is low: FSM in IDLE, all counters 0, synchronizer flops 1, slot_data 8'h00, slot_addr 0, all strobes 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no strobes. After release, reception SHALL resume only after a complete break.

Configuration
REQ-031 Macro DMX_RX_START_CODE_FILTER_EN SHALL control start-code filtering.
REQ-032 With DMX_RX_START_CODE_FILTER_EN defined, a slot-0 byte other than 8'h00:
- SHALL produce no slot_valid for that frame;
- SHALL pulse no frame_end for that frame;
- SHALL return the FSM to IDLE.
REQ-033 Without DMX_RX_START_CODE_FILTER_EN, every start code SHALL be delivered as slot 0.

Verification
REQ-034 Break 1100 cycles, MAB 100, slots 00,12,34 at CLK_DIV=48, then break -> frame_start; slot_valid with (0,00),(1,12),(2,34); frame_end at the second break.
REQ-035 Full frame of 513 slots, slot n = n[7:0] -> 513 slot_valid, last at slot_addr 512 data 8'h00; frame_end one cycle after the final slot_valid; IDLE.
REQ-036 Break, then MAB of 50 cycles -> frame_err pulse; no frame_start; no slot_valid until the next valid break+MAB.
REQ-037 Slot 3 with STOP1 driven low -> frame_err; no slot_valid for slot 3; the following break gives frame_end.
REQ-038 Start code 8'hCC with filter macro defined -> no slot_valid and no frame_end. Without the macro -> slot_valid (0,CC).
REQ-039 rst_n pulsed low during slot 5 -> all outputs 0. The next break then gives frame_start and slot_addr restarting at 0.

Source files
------------

// File: rtl/dmx_rx.sv
// DMX512 receiver: synchronizes RX, detects break / mark-after-break, and
// deframes 8N2 slots at 250 kbaud, reporting each slot with its index.
// Optional feature: define DMX_RX_START_CODE_FILTER_EN to drop any frame
// whose start code (slot 0) is not 8'h00.
module dmx_rx #(
  parameter int CLK_DIV   = 48,
  parameter int BREAK_MIN = 1064,
  parameter int MAB_MIN   = 97
) (
  input  logic       clk_In,
  input  logic       rst_n,
  input  logic       RX,
  output logic [7:0] slot_data,
  output logic [9:0] slot_addr,
  output logic       slot_valid,
  output logic       frame_start,
  output logic       frame_end,
  output logic       frame_err
);

  localparam int LOW_W  = $clog2(BREAK_MIN + 2);
  localparam int HIGH_W = $clog2(MAB_MIN + 2);
  localparam int TMR_W  = $clog2(CLK_DIV + 2);

  localparam logic [LOW_W-1:0]  BREAK_LIM = LOW_W'(BREAK_MIN);
  localparam logic [HIGH_W-1:0] MAB_LIM   = HIGH_W'(MAB_MIN);
  localparam logic [TMR_W-1:0]  HALF_LAST = TMR_W'(CLK_DIV / 2 - 1);
  localparam logic [TMR_W-1:0]  BIT_LAST  = TMR_W'(CLK_DIV - 1);
  localparam logic [9:0]        LAST_SLOT = 10'd512;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BREAK,
    S_MAB,
    S_START,
    S_DATA,
    S_STOP1,
    S_STOP2
  } state_e;

  state_e             state_q, state_d;
  logic               rx_meta_q, rx_meta_d;
  logic               rx_sync_q, rx_sync_d;
  logic [LOW_W-1:0]   low_cnt_q, low_cnt_d;
  logic [HIGH_W-1:0]  high_cnt_q, high_cnt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [9:0]         next_addr_q, next_addr_d;
  logic               mark_q, mark_d;        // slot delivered, waiting for next start edge
  logic               slot_seen_q, slot_seen_d;
  logic [7:0]         slot_data_q, slot_data_d;
  logic [9:0]         slot_addr_q, slot_addr_d;
  logic               slot_valid_q, slot_valid_d;
  logic               frame_start_q, frame_start_d;
  logic               frame_end_q, frame_end_d;
  logic               frame_err_q, frame_err_d;
  logic               break_hit;

  // Break is a saturated low-run seen outside BREAK; it overrides every state.
  assign break_hit = (low_cnt_q == BREAK_LIM) && (state_q != S_BREAK);

  // Next-state and datapath logic for the receiver FSM.
  always_comb begin
    // NOTE: every signal gets a default here so no path can infer a latch.
    state_d       = state_q;
    rx_meta_d     = RX;
    rx_sync_d     = rx_meta_q;
    high_cnt_d    = high_cnt_q;
    tmr_d         = tmr_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    next_addr_d   = next_addr_q;
    mark_d        = mark_q;
    slot_seen_d   = slot_seen_q;
    slot_data_d   = slot_data_q;
    slot_addr_d   = slot_addr_q;
    slot_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    frame_err_d   = 1'b0;

    if (rx_sync_q) begin
      low_cnt_d = '0;
    end else if (low_cnt_q != BREAK_LIM) begin
      low_cnt_d = low_cnt_q + 1'b1;
    end else begin
      low_cnt_d = low_cnt_q;
    end

    unique case (state_q)
      S_IDLE: begin
        // Only the break detector below can leave IDLE.
      end

      S_BREAK: begin
        if (rx_sync_q) begin
          state_d    = S_MAB;
          high_cnt_d = '0;
        end
      end

      S_MAB: begin
        if (rx_sync_q) begin
          if (high_cnt_q != MAB_LIM) high_cnt_d = high_cnt_q + 1'b1;
        end else if (high_cnt_q >= MAB_LIM) begin
          frame_start_d = 1'b1;
          next_addr_d   = '0;
          tmr_d         = '0;
          state_d       = S_START;
        end else begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      S_START: begin
        if (tmr_q == HALF_LAST) begin
          tmr_d = '0;
          if (!rx_sync_q) begin
            bit_cnt_d = '0;
            state_d   = S_DATA;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      S_DATA: begin
        if (tmr_q == BIT_LAST) begin
          tmr_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) state_d = S_STOP1;
          else                   bit_cnt_d = bit_cnt_q + 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      S_STOP1: begin
        if (tmr_q == BIT_LAST) begin
          tmr_d = '0;
          if (rx_sync_q) begin
            mark_d  = 1'b0;
            state_d = S_STOP2;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      S_STOP2: begin
        if (mark_q) begin
          if (slot_addr_q == LAST_SLOT) begin
            frame_end_d = 1'b1;
            slot_seen_d = 1'b0;
            mark_d      = 1'b0;
            state_d     = S_IDLE;
          end else if (!rx_sync_q) begin
            mark_d  = 1'b0;
            tmr_d   = '0;
            state_d = S_START;
          end
        end else if (tmr_q == BIT_LAST) begin
          tmr_d = '0;
          if (!rx_sync_q) begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
`ifdef DMX_RX_START_CODE_FILTER_EN
          end else if ((next_addr_q == 10'd0) && (shift_q != 8'h00)) begin
            state_d = S_IDLE;
`endif
          end else begin
            slot_valid_d = 1'b1;
            slot_data_d  = shift_q;
            slot_addr_d  = next_addr_q;
            next_addr_d  = next_addr_q + 1'b1;
            slot_seen_d  = 1'b1;
            mark_d       = 1'b1;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Break wins over anything decided above, including a same-cycle stop sample.
    if (break_hit) begin
      state_d       = S_BREAK;
      frame_end_d   = slot_seen_q;
      slot_seen_d   = 1'b0;
      slot_valid_d  = 1'b0;
      frame_start_d = 1'b0;
      frame_err_d   = 1'b0;
      slot_data_d   = slot_data_q;
      slot_addr_d   = slot_addr_q;
      next_addr_d   = next_addr_q;
      mark_d        = 1'b0;
    end
  end

  // State and output registers; reset aborts any frame without strobes.
  always_ff @(posedge clk_In or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
      low_cnt_q     <= '0;
      high_cnt_q    <= '0;
      tmr_q         <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      next_addr_q   <= '0;
      mark_q        <= 1'b0;
      slot_seen_q   <= 1'b0;
      slot_data_q   <= '0;
      slot_addr_q   <= '0;
      slot_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q       <= state_d;
      rx_meta_q     <= rx_meta_d;
      rx_sync_q     <= rx_sync_d;
      low_cnt_q     <= low_cnt_d;
      high_cnt_q    <= high_cnt_d;
      tmr_q         <= tmr_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      next_addr_q   <= next_addr_d;
      mark_q        <= mark_d;
      slot_seen_q   <= slot_seen_d;
      slot_data_q   <= slot_data_d;
      slot_addr_q   <= slot_addr_d;
      slot_valid_q  <= slot_valid_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign slot_data   = slot_data_q;
  assign slot_addr   = slot_addr_q;
  assign slot_valid  = slot_valid_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign frame_err   = frame_err_q;

endmodule
